// File: rtl/jtframe_cen_multi.sv
// rtl/jtframe_cen_multi.sv - multi-channel fractional N/M clock-enable generator
// Each channel runs a modulo-m accumulator stepping by n; cen fires on wrap.
module jtframe_cen_multi #(
   parameter  int CHANNELS = 4,
   parameter  int W        = 10,
   parameter  int DEF_N    = 1,
   parameter  int DEF_M    = 6,
   parameter  int LOCK_CNT = 16,
   localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int LW       = $clog2(LOCK_CNT + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [CHW-1:0]      cfg_ch,
   input  logic [W-1:0]        cfg_n,
   input  logic [W-1:0]        cfg_m,
   input  logic                sync,
   output logic [CHANNELS-1:0] cen,
   output logic [CHANNELS-1:0] clkdiv,
   output logic [CHANNELS-1:0] ch_locked,
   output logic                locked
);

   logic [W-1:0] cfg_n_clamped;

   assign cfg_n_clamped = (cfg_n > cfg_m) ? cfg_m : cfg_n;

   genvar i;
   generate
      for (i = 0; i < CHANNELS; i++) begin : g_ch
         logic [W-1:0]  n, m, acc;
         logic [W:0]    sum;
         logic [LW-1:0] lcnt;
         logic          cen_r, div_r, lock_r;
         logic          we, run, fire;

         // Indices at or above CHANNELS never match, so such writes are dropped.
         assign we   = cfg_we && (cfg_ch == CHW'(i));
         assign run  = (n != '0) && (m != '0);
         assign sum  = {1'b0, acc} + {1'b0, n};
         assign fire = (sum >= {1'b0, m});

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               n      <= W'(DEF_N);
               m      <= W'(DEF_M);
               acc    <= '0;
               cen_r  <= 1'b0;
               div_r  <= 1'b0;
               lcnt   <= '0;
               lock_r <= 1'b0;
            end else if (we) begin
               n      <= cfg_n_clamped;
               m      <= cfg_m;
               acc    <= '0;
               cen_r  <= 1'b0;
               div_r  <= 1'b0;
               lcnt   <= '0;
               lock_r <= 1'b0;
            end else if (!run) begin
               cen_r  <= 1'b0;
               lcnt   <= '0;
               lock_r <= 1'b0;
            end else if (sync) begin
               // Preload so the very next step wraps on every running channel.
               acc   <= m - n;
               cen_r <= 1'b0;
               div_r <= 1'b0;
            end else begin
               cen_r <= fire;
               if (fire) begin
                  acc   <= W'(sum - {1'b0, m});
                  div_r <= ~div_r;
                  if (lcnt != LW'(LOCK_CNT)) begin
                     lcnt <= lcnt + 1'b1;
                     if (lcnt == LW'(LOCK_CNT - 1))
                        lock_r <= 1'b1;
                  end
               end else begin
                  acc <= sum[W-1:0];
               end
            end
         end

         assign cen[i]       = cen_r;
         assign clkdiv[i]    = div_r;
         assign ch_locked[i] = lock_r;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         locked <= 1'b0;
      else
         locked <= &ch_locked;
   end

endmodule

// File: tb/tb_jtframe_cen_multi.sv
// tb/tb_jtframe_cen_multi.sv - directed self-checking bench for jtframe_cen_multi
module tb_jtframe_cen_multi;
   localparam int CH = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_ch = '0;
   logic [9:0]    cfg_n = '0;
   logic [9:0]    cfg_m = '0;
   logic          sync = 1'b0;
   logic [CH-1:0] cen, clkdiv, ch_locked;
   logic          locked;

   int checks = 0;
   int failures = 0;
   int edge_no = 0;

   jtframe_cen_multi #(.CHANNELS(CH), .W(10), .DEF_N(1), .DEF_M(6), .LOCK_CNT(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_n(cfg_n),
      .cfg_m(cfg_m), .sync(sync), .cen(cen), .clkdiv(clkdiv),
      .ch_locked(ch_locked), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      edge_no++;
      @(negedge clk);
   endtask

   task automatic write_cfg(input logic [2:0] ch, input logic [9:0] n, input logic [9:0] m,
                            input logic with_sync);
      cfg_we = 1'b1; cfg_ch = ch; cfg_n = n; cfg_m = m; sync = with_sync;
      tick();
      cfg_we = 1'b0; sync = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({cen, clkdiv, ch_locked, locked} !== '0) begin
         failures++;
         $display("FAIL reset_outputs cen=%b clkdiv=%b ch_locked=%b locked=%b required all 0",
                  cen, clkdiv, ch_locked, locked);
      end
   endtask

   task automatic test_defaults();
      @(negedge clk);
      rst_n = 1'b1;
      edge_no = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         checks++;
         if (cen !== ((k % 6 == 0) ? 5'h1f : 5'h00)) begin
            failures++; $display("FAIL def_cen edge=%0d got=%b", k, cen);
         end
         checks++;
         if (clkdiv !== (((k / 6) % 2 == 1) ? 5'h1f : 5'h00)) begin
            failures++; $display("FAIL def_clkdiv edge=%0d got=%b", k, clkdiv);
         end
         checks++;
         if (ch_locked !== ((k >= 96) ? 5'h1f : 5'h00)) begin
            failures++; $display("FAIL def_ch_locked edge=%0d got=%b", k, ch_locked);
         end
         checks++;
         if (locked !== (k >= 97)) begin
            failures++; $display("FAIL def_locked edge=%0d got=%b required=%b", k, locked, k >= 97);
         end
      end
   endtask

   task automatic test_fractional();
      logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      int   pulses = 0;
      logic prev = 1'b0;
      write_cfg(3'd1, 10'd3, 10'd8, 1'b0);
      for (int k = 1; k <= 800; k++) begin
         tick();
         checks++;
         if (cen[1] !== pat[(k - 1) % 8]) begin
            failures++; $display("FAIL frac_cen1 k=%0d got=%b required=%b", k, cen[1], pat[(k - 1) % 8]);
         end
         checks++;
         if (prev && cen[1]) begin
            failures++; $display("FAIL frac_consecutive k=%0d got=1 required=0", k);
         end
         checks++;
         if (cen[0] !== (edge_no % 6 == 0) || cen[4] !== (edge_no % 6 == 0)) begin
            failures++; $display("FAIL frac_others k=%0d got=%b required=%b", k, cen, edge_no % 6 == 0);
         end
         checks++;
         if (ch_locked[1] !== (k >= 43) || locked !== (k >= 44)) begin
            failures++; $display("FAIL frac_lock k=%0d got=%b/%b", k, ch_locked[1], locked);
         end
         prev = cen[1];
         if (cen[1]) pulses++;
      end
      checks++;
      if (pulses != 300) begin
         failures++; $display("FAIL frac_pulse_count got=%0d required=300", pulses);
      end
   endtask

   task automatic test_clamp();
      write_cfg(3'd2, 10'd5, 10'd4, 1'b0);
      checks++;
      if (cen[2] !== 1'b0 || ch_locked[2] !== 1'b0) begin
         failures++; $display("FAIL clamp_write_edge got=%b/%b required=0/0", cen[2], ch_locked[2]);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (cen[2] !== 1'b1) begin
            failures++; $display("FAIL clamp_cen k=%0d got=%b required=1", k, cen[2]);
         end
         checks++;
         if (ch_locked[2] !== (k >= 16) || locked !== (k >= 17)) begin
            failures++; $display("FAIL clamp_lock k=%0d got=%b/%b", k, ch_locked[2], locked);
         end
      end
   endtask

   task automatic test_stop();
      write_cfg(3'd3, 10'd0, 10'd6, 1'b0);
      checks++;
      if (cen[3] !== 1'b0 || ch_locked[3] !== 1'b0 || clkdiv[3] !== 1'b0) begin
         failures++; $display("FAIL stop_write_edge got=%b/%b/%b required=0/0/0", cen[3], ch_locked[3], clkdiv[3]);
      end
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (cen[3] !== 1'b0 || clkdiv[3] !== 1'b0 || locked !== 1'b0) begin
            failures++; $display("FAIL stop_idle k=%0d got=%b/%b/%b required=0/0/0", k, cen[3], clkdiv[3], locked);
         end
      end
      write_cfg(3'd3, 10'd1, 10'd2, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         tick();
         checks++;
         if (cen[3] !== (k % 2 == 0)) begin
            failures++; $display("FAIL relock_cen k=%0d got=%b required=%b", k, cen[3], k % 2 == 0);
         end
         checks++;
         if (ch_locked[3] !== (k >= 32) || locked !== (k >= 33)) begin
            failures++; $display("FAIL relock_lock k=%0d got=%b/%b", k, ch_locked[3], locked);
         end
      end
   endtask

   task automatic test_sync();
      write_cfg(3'd1, 10'd1, 10'd7, 1'b0);
      repeat (3) tick();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      checks++;
      if (cen !== 5'h00) begin
         failures++; $display("FAIL sync_edge got=%b required=00000", cen);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) begin
            checks++;
            if (cen !== 5'h1f || clkdiv[1:0] !== 2'b11) begin
               failures++; $display("FAIL sync_align got=%b/%b required=11111/11", cen, clkdiv[1:0]);
            end
         end
         checks++;
         if (cen[0] !== (k == 1 || k == 7) || cen[1] !== (k == 1 || k == 8) || cen[4] !== (k == 1 || k == 7)) begin
            failures++; $display("FAIL sync_follow k=%0d got=%b", k, cen);
         end
         checks++;
         if (ch_locked[0] !== 1'b1 || ch_locked[4] !== 1'b1) begin
            failures++; $display("FAIL sync_lock_kept k=%0d got=%b", k, ch_locked);
         end
      end
      write_cfg(3'd0, 10'd1, 10'd6, 1'b1);
      checks++;
      if (cen !== 5'h00) begin
         failures++; $display("FAIL syncwe_edge got=%b required=00000", cen);
      end
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if (cen[0] !== (k == 6) || cen[1] !== (k == 1 || k == 8) || cen[4] !== (k == 1 || k == 7)) begin
            failures++; $display("FAIL syncwe_follow k=%0d got=%b", k, cen);
         end
         checks++;
         if (ch_locked[0] !== 1'b0) begin
            failures++; $display("FAIL syncwe_lock k=%0d got=%b required=0", k, ch_locked[0]);
         end
      end
   endtask

   task automatic test_bad_channel();
      sync = 1'b1;
      tick();
      sync = 1'b0;
      write_cfg(3'd5, 10'd0, 10'd0, 1'b0);
      checks++;
      if (cen[0] !== 1'b1 || cen[4] !== 1'b1 || clkdiv[4] !== 1'b1) begin
         failures++; $display("FAIL badch_fire got=%b/%b required cen[0]=cen[4]=clkdiv[4]=1", cen, clkdiv);
      end
      write_cfg(3'd7, 10'd0, 10'd0, 1'b0);
      for (int k = 3; k <= 8; k++) begin
         tick();
         checks++;
         if (cen[0] !== (k == 7) || cen[4] !== (k == 7) || ch_locked[4] !== 1'b1) begin
            failures++; $display("FAIL badch_follow k=%0d got=%b/%b", k, cen, ch_locked);
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({cen, clkdiv, ch_locked, locked} !== '0) begin
         failures++;
         $display("FAIL async_reset cen=%b clkdiv=%b ch_locked=%b locked=%b required all 0",
                  cen, clkdiv, ch_locked, locked);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++;
         if (cen !== ((k == 6) ? 5'h1f : 5'h00)) begin
            failures++; $display("FAIL reset_defaults k=%0d got=%b", k, cen);
         end
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_fractional();
      test_clamp();
      test_stop();
      test_sync();
      test_bad_channel();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
